fifo_sync_param: RTL and testbench



---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_mem.sv | 32 +++
 rtl/fifo_sync_param.sv | 112 +++++++++++
 tb/tb_fifo_sync_param.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg                                                             |
// | Shared types and elaboration helpers for the parametrised sync FIFO. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit fifo_cfg_ok(input int depth, input int afull_th, input int aempty_th);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_mem                                                             |
// | Unreset register array: synchronous write, asynchronous read.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_sync_param                                                      |
// | Single-clock FIFO with thresholds, occupancy, error pulses and FWFT. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    pop,
  output logic [WIDTH-1:0]        data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int         AW   = $clog2(DEPTH);
  localparam int         CW   = cnt_w(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  if (!fifo_cfg_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_cfg_err
    $error("fifo_sync_param: DEPTH must be a power of two >= 2 and thresholds in range");
  end

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] rd_data;

  // A push into a full FIFO is still accepted when the head is popped the same edge.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    ovf_d    = push & ~wr_en;
    udf_d    = pop & ~rd_en;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign count        = count_q;
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AFULL_TH));
  assign almost_empty = (count_q <= CW'(AEMPTY_TH));
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign data_out = empty ? '0 : rd_data;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_en) begin
        dout_q <= rd_data;
      end
    end
    assign data_out = dout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_sync_param                                                   |
// | Scoreboard bench for standard and FWFT instances of the FIFO.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fifo_sync_param;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 1;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          s_push, s_pop, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [W-1:0]  s_din, s_dout;
  logic [CW-1:0] s_cnt;
  logic          f_push, f_pop, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [W-1:0]  f_din, f_dout;
  logic [CW-1:0] f_cnt;

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .push(s_push), .data_in(s_din), .pop(s_pop), .data_out(s_dout),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_cnt), .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .push(f_push), .data_in(f_din), .pop(f_pop), .data_out(f_dout),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_cnt), .overflow(f_ovf), .underflow(f_udf)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] s_sb[$];
  logic [W-1:0] f_sb[$];
  logic [W-1:0] s_exp_word;

  // Drive one cycle on the standard instance; the scoreboard follows the accept rules.
  task automatic std_cycle(input logic p, input logic [W-1:0] d, input logic q);
    logic wr, rd;
    @(negedge clk);
    s_push = p; s_din = d; s_pop = q;
    wr = p && ((s_sb.size() < D) || q);
    rd = q && (s_sb.size() > 0);
    if (rd) s_exp_word = s_sb.pop_front();
    if (wr) s_sb.push_back(d);
    @(posedge clk); #1;
    s_push = 1'b0; s_pop = 1'b0;
  endtask

  task automatic fwft_cycle(input logic p, input logic [W-1:0] d, input logic q);
    logic wr, rd;
    @(negedge clk);
    f_push = p; f_din = d; f_pop = q;
    wr = p && ((f_sb.size() < D) || q);
    rd = q && (f_sb.size() > 0);
    if (rd) void'(f_sb.pop_front());
    if (wr) f_sb.push_back(d);
    @(posedge clk); #1;
    f_push = 1'b0; f_pop = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst = 1'b1;
    s_push = 0; s_pop = 0; s_din = '0;
    f_push = 0; f_pop = 0; f_din = '0;
    @(posedge clk); #1;
    got = {s_cnt, s_empty, s_ae, s_full, s_af, s_ovf, s_udf, s_dout[5:0]};
    checks++;
    if (got !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0}) begin
      errors++; $display("FAIL reset_std_state: got %h expected %h", got, 16'h0C00);
    end
    checks++;
    if ({f_cnt, f_empty, f_ae, f_full, f_af, f_dout} !== {4'd0, 4'b1100, 8'h00}) begin
      errors++; $display("FAIL reset_fwft_state: got cnt=%0d empty=%b dout=%h expected cnt=0 empty=1 dout=00",
                         f_cnt, f_empty, f_dout);
    end
    checks++;
    if (s_dout !== 8'h00) begin
      errors++; $display("FAIL reset_std_dout: got %h expected 00", s_dout);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < D; i++) begin
      std_cycle(1'b1, 8'h10 + W'(i), 1'b0);
      checks++;
      if (s_cnt !== CW'(i + 1)) begin
        errors++; $display("FAIL fill_count: got %0d expected %0d", s_cnt, i + 1);
      end
      checks++;
      if ({s_af, s_full, s_ae, s_empty} !== {(i + 1 >= AF), (i + 1 == D), (i + 1 <= AE), 1'b0}) begin
        errors++; $display("FAIL fill_flags at count %0d: got af/full/ae/empty=%b%b%b%b expected %b%b%b0",
                           i + 1, s_af, s_full, s_ae, s_empty, (i + 1 >= AF), (i + 1 == D), (i + 1 <= AE));
      end
    end
    for (int i = 0; i < D; i++) begin
      std_cycle(1'b0, '0, 1'b1);
      checks++;
      if (s_dout !== 8'h10 + W'(i)) begin
        errors++; $display("FAIL drain_data: got %h expected %h", s_dout, 8'h10 + W'(i));
      end
      checks++;
      if (s_cnt !== CW'(D - 1 - i)) begin
        errors++; $display("FAIL drain_count: got %0d expected %0d", s_cnt, D - 1 - i);
      end
    end
    checks++;
    if (s_empty !== 1'b1) begin
      errors++; $display("FAIL drain_empty: got %b expected 1", s_empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D; i++) std_cycle(1'b1, 8'h20 + W'(i), 1'b0);
    std_cycle(1'b1, 8'hAA, 1'b0);
    checks++;
    if ({s_ovf, s_cnt} !== {1'b1, 4'd8}) begin
      errors++; $display("FAIL overflow_pulse: got ovf=%b cnt=%0d expected ovf=1 cnt=8", s_ovf, s_cnt);
    end
    std_cycle(1'b0, '0, 1'b0);
    checks++;
    if ({s_ovf, s_cnt} !== {1'b0, 4'd8}) begin
      errors++; $display("FAIL overflow_clear: got ovf=%b cnt=%0d expected ovf=0 cnt=8", s_ovf, s_cnt);
    end
  endtask

  task automatic test_simul_full();
    std_cycle(1'b1, 8'h55, 1'b1);
    checks++;
    if ({s_ovf, s_cnt, s_dout} !== {1'b0, 4'd8, 8'h20}) begin
      errors++; $display("FAIL simul_full: got ovf=%b cnt=%0d dout=%h expected ovf=0 cnt=8 dout=20",
                         s_ovf, s_cnt, s_dout);
    end
    for (int i = 0; i < D; i++) begin
      std_cycle(1'b0, '0, 1'b1);
      checks++;
      if (s_dout !== s_exp_word || s_dout === 8'hAA) begin
        errors++; $display("FAIL simul_full_drain: got %h expected %h", s_dout, s_exp_word);
      end
    end
    checks++;
    if ({s_dout, s_empty} !== {8'h55, 1'b1}) begin
      errors++; $display("FAIL simul_full_last: got dout=%h empty=%b expected dout=55 empty=1", s_dout, s_empty);
    end
  endtask

  task automatic test_simul_empty();
    std_cycle(1'b1, 8'h66, 1'b1);
    checks++;
    if ({s_cnt, s_udf, s_ovf} !== {4'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL simul_empty: got cnt=%0d udf=%b ovf=%b expected cnt=1 udf=1 ovf=0",
                         s_cnt, s_udf, s_ovf);
    end
    std_cycle(1'b0, '0, 1'b1);
    checks++;
    if ({s_dout, s_cnt, s_udf} !== {8'h66, 4'd0, 1'b0}) begin
      errors++; $display("FAIL simul_empty_read: got dout=%h cnt=%0d udf=%b expected dout=66 cnt=0 udf=0",
                         s_dout, s_cnt, s_udf);
    end
  endtask

  task automatic test_reset_midfill();
    for (int i = 0; i < 3; i++) std_cycle(1'b1, 8'h31 + W'(i), 1'b0);
    std_cycle(1'b0, '0, 1'b1);
    checks++;
    if (s_dout !== 8'h31) begin
      errors++; $display("FAIL midfill_pre: got %h expected 31", s_dout);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({s_cnt, s_empty, s_ae, s_dout} !== {4'd0, 1'b1, 1'b1, 8'h00}) begin
      errors++; $display("FAIL midfill_async_reset: got cnt=%0d empty=%b ae=%b dout=%h expected 0 1 1 00",
                         s_cnt, s_empty, s_ae, s_dout);
    end
    s_sb.delete();
    f_sb.delete();
    @(negedge clk);
    rst = 1'b0;
    std_cycle(1'b0, '0, 1'b1);
    checks++;
    if (s_udf !== 1'b1) begin
      errors++; $display("FAIL midfill_underflow: got %b expected 1", s_udf);
    end
    std_cycle(1'b0, '0, 1'b0);
    checks++;
    if (s_udf !== 1'b0) begin
      errors++; $display("FAIL midfill_underflow_clear: got %b expected 0", s_udf);
    end
  endtask

  task automatic test_fwft_wrap();
    for (int i = 0; i < 20; i++) begin
      fwft_cycle(1'b1, 8'h80 + W'(i), 1'b0);
      checks++;
      if ({f_dout, f_cnt} !== {8'h80 + W'(i), 4'd1}) begin
        errors++; $display("FAIL fwft_show: got dout=%h cnt=%0d expected dout=%h cnt=1",
                           f_dout, f_cnt, 8'h80 + W'(i));
      end
      fwft_cycle(1'b0, '0, 1'b1);
      checks++;
      if ({f_dout, f_cnt, f_empty, f_udf} !== {8'h00, 4'd0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL fwft_ack: got dout=%h cnt=%0d empty=%b udf=%b expected 00 0 1 0",
                           f_dout, f_cnt, f_empty, f_udf);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] head;
    for (int i = 0; i < 3; i++) fwft_cycle(1'b1, 8'hC0 + W'(i), 1'b0);
    for (int i = 0; i < 12; i++) begin
      fwft_cycle(1'b1, 8'hD0 + W'(i), 1'b1);
      head = f_sb[0];
      checks++;
      if ({f_dout, f_cnt, f_ovf, f_udf} !== {head, 4'd3, 1'b0, 1'b0}) begin
        errors++; $display("FAIL b2b_stream: got dout=%h cnt=%0d ovf=%b udf=%b expected dout=%h cnt=3 ovf=0 udf=0",
                           f_dout, f_cnt, f_ovf, f_udf, head);
      end
    end
    while (f_sb.size() > 0) begin
      fwft_cycle(1'b0, '0, 1'b1);
      head = (f_sb.size() > 0) ? f_sb[0] : 8'h00;
      checks++;
      if (f_dout !== head) begin
        errors++; $display("FAIL b2b_drain: got %h expected %h", f_dout, head);
      end
    end
    checks++;
    if ({f_empty, f_ae} !== 2'b11) begin
      errors++; $display("FAIL b2b_end_flags: got empty/ae=%b%b expected 11", f_empty, f_ae);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simul_full();
    test_simul_empty();
    test_reset_midfill();
    test_fwft_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
